// File: rtl/io_map_pkg.sv
// Register map and status-bit layout for the MMIO responder.
// Shared by the responder top, its transmit FIFO and anything decoding its status word.
package io_map_pkg;

    localparam int IO_SEL_BIT = 31;

    localparam logic [7:0] IO_CTRL = 8'h00;
    localparam logic [7:0] IO_RX   = 8'h04;
    localparam logic [7:0] IO_TX   = 8'h08;
    localparam logic [7:0] IO_CYC  = 8'h10;
    localparam logic [7:0] IO_INST = 8'h14;
    localparam logic [7:0] IO_CRST = 8'h18;

    localparam int CTRL_TX_NFULL = 0;
    localparam int CTRL_RX_FULL  = 1;
    localparam int CTRL_TX_OVF   = 2;

    function automatic logic [31:0] pack_status(input logic tx_nfull,
                                                input logic rx_full,
                                                input logic tx_ovf);
        logic [31:0] st;
        st = '0;
        st[CTRL_TX_NFULL] = tx_nfull;
        st[CTRL_RX_FULL]  = rx_full;
        st[CTRL_TX_OVF]   = tx_ovf;
        return st;
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the UART serializer; full/empty come from the pre-cycle count,
// so a push while full is refused even when a pop happens in the same cycle.
module io_tx_fifo
    import io_map_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_DEPTH);

    logic [7:0]    mem [TX_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_io_responder.sv
// Data-side MMIO responder: UART transmit FIFO, receive holding register, status, counters.
// Define MMIO_COUNTERS_EN to include the cycle/instruction counters and their 0x18 reset.
module mmio_io_responder
    import io_map_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] dout,
    input  logic        instr_retired,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    logic        sel;
    logic        wr_any;
    logic        rd_any;
    logic [7:0]  off;
    logic        rx_full;
    logic [7:0]  rx_hold;
    logic        rx_pop;
    logic        rx_cap;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_ovf;
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rdata;
    logic        unused_bits;

    assign sel    = addr[IO_SEL_BIT] & ~stall;
    assign off    = addr[7:0];
    assign wr_any = sel & (|we);
    assign rd_any = sel & re;

    assign unused_bits = ^{addr[30:8], din[31:8]};

    // Pop and capture are exclusive: one needs the register full, the other empty.
    assign rx_pop   = rd_any & (off == IO_RX) & rx_full;
    assign rx_cap   = rx_valid & ~rx_full;
    assign rx_ready = ~rx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full <= 1'b0;
            rx_hold <= '0;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end else if (rx_cap) begin
            rx_full <= 1'b1;
            rx_hold <= rx_data;
        end
    end

    assign tx_push  = wr_any & (off == IO_TX) & we[0];
    assign tx_pop   = ~tx_empty & tx_ready;
    assign tx_valid = ~tx_empty;

    io_tx_fifo #(
        .TX_DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (din[7:0]),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            tx_ovf <= 1'b0;
        else if (tx_push & tx_full)
            tx_ovf <= 1'b1;
        else if (wr_any & (off == IO_CTRL))
            tx_ovf <= 1'b0;
    end

`ifdef MMIO_COUNTERS_EN
    logic cnt_clr;

    assign cnt_clr = wr_any & (off == IO_CRST);

    // The clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst | cnt_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 1'b1;
            inst_cnt <= inst_cnt + {31'b0, instr_retired};
        end
    end
`else
    logic unused_retired;

    assign unused_retired = instr_retired;
    assign cyc_cnt        = '0;
    assign inst_cnt       = '0;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            IO_CTRL: rdata = pack_status(~tx_full, rx_full, tx_ovf);
            IO_RX:   rdata = {24'b0, rx_hold};
            IO_CYC:  rdata = cyc_cnt;
            IO_INST: rdata = inst_cnt;
            default: rdata = '0;
        endcase
    end

    // Read data is taken from pre-edge state, so a read+write returns the old value.
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (rd_any)
            dout <= rdata;
    end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: directed steps plus random traffic against a queue-based model.
module tb_mmio_io_responder;
    import io_map_pkg::*;

    localparam int TXD = 8;
`ifdef MMIO_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dout;
    logic        instr_retired;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0]  m_txq[$];
    bit          m_ovf;
    bit          m_rxf;
    logic [7:0]  m_rxb;
    logic [31:0] m_dout;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;

    mmio_io_responder #(
        .TX_DEPTH (TXD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .addr          (addr),
        .din           (din),
        .we            (we),
        .re            (re),
        .dout          (dout),
        .instr_retired (instr_retired),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] o);
        case (o)
            8'h00:   return {29'b0, m_ovf, m_rxf, (m_txq.size() < TXD)};
            8'h04:   return {24'b0, m_rxb};
            8'h10:   return CNT_EN ? m_cyc : 32'd0;
            8'h14:   return CNT_EN ? m_inst : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_state();
        check("tx_valid", {31'b0, tx_valid}, {31'b0, m_txq.size() != 0});
        if (m_txq.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, m_txq[0]});
        check("rx_ready", {31'b0, rx_ready}, {31'b0, !m_rxf});
        check("dout", dout, m_dout);
    endtask

    // One bus cycle: drive, advance the model from the pre-edge state, clock, compare.
    task automatic drive_cycle(input bit a31, input bit stl, input logic [7:0] o,
                               input logic [31:0] data, input logic [3:0] wen, input bit rden);
        bit is_wr;
        bit is_rd;
        bit full_pre;
        addr  = {a31, 23'($urandom), o};
        stall = stl;
        din   = data;
        we    = wen;
        re    = rden;
        is_wr = a31 && !stl && (wen != 4'b0);
        is_rd = a31 && !stl && rden;
        if (is_rd) m_dout = model_read(o);
        full_pre = (m_txq.size() == TXD);
        if (m_txq.size() != 0 && tx_ready) void'(m_txq.pop_front());
        if (is_wr && o == 8'h08 && wen[0]) begin
            if (full_pre) m_ovf = 1'b1;
            else m_txq.push_back(data[7:0]);
        end
        if (is_wr && o == 8'h00) m_ovf = 1'b0;
        if (is_rd && o == 8'h04 && m_rxf) m_rxf = 1'b0;
        else if (rx_valid && !m_rxf) begin
            m_rxf = 1'b1;
            m_rxb = rx_data;
        end
        if (is_wr && o == 8'h18) begin
            m_cyc  = 32'd0;
            m_inst = 32'd0;
        end else begin
            m_cyc  = m_cyc + 32'd1;
            m_inst = m_inst + {31'b0, instr_retired};
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] o);
        drive_cycle(1'b1, 1'b0, o, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] data);
        drive_cycle(1'b1, 1'b0, o, data, 4'hF, 1'b0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        addr  = '0;
        din   = '0;
        we    = '0;
        re    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_txq.delete();
        m_ovf  = 1'b0;
        m_rxf  = 1'b0;
        m_rxb  = 8'h00;
        m_dout = 32'h0;
        m_cyc  = 32'h0;
        m_inst = 32'h0;
    endtask

    initial begin
        logic [7:0] offs [7];
        bit         pat [100];
        bit         tmp;
        int         j;
        int         op;

        offs = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h0C, 8'h18, 8'h40};
        rst = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        instr_retired = 1'b0;

        // Reset state and first status read
        do_reset();
        check("rst_dout", dout, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        rd(IO_CTRL);
        check("rst_ctrl", dout, 32'h1);

        // Three bytes queued, then drained in order
        wr(IO_TX, 32'h41);
        wr(IO_TX, 32'hFFFF_FF42);
        wr(IO_TX, 32'h43);
        check("tx_head0", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        idle();
        check("tx_head1", {24'b0, tx_data}, 32'h42);
        idle();
        check("tx_head2", {24'b0, tx_data}, 32'h43);
        idle();
        check("tx_drained", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Overflow on the ninth push; read+write of status returns the old value and clears it
        for (int i = 0; i < 9; i++) wr(IO_TX, 32'h60 + i);
        drive_cycle(1'b1, 1'b0, IO_CTRL, 32'h0, 4'hF, 1'b1);
        check("ovf_status", dout, 32'h4);
        rd(IO_CTRL);
        check("ovf_cleared", dout, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < TXD; i++) begin
            check("ovf_drain", {24'b0, tx_data}, 32'h60 + i);
            idle();
        end
        check("ovf_empty", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Unmapped and write-only offsets
        wr(8'h0C, 32'hDEAD_BEEF);
        rd(8'h0C);
        check("unmapped_rd", dout, 32'h0);
        rd(IO_TX);
        check("wo_tx_rd", dout, 32'h0);

        // Receive capture and read-out
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        idle();
        rx_valid = 1'b0;
        check("rx_ready_low", {31'b0, rx_ready}, 32'h0);
        rd(IO_CTRL);
        check("rx_status", dout, 32'h3);
        rd(IO_RX);
        check("rx_data", dout, 32'h5A);
        check("rx_ready_high", {31'b0, rx_ready}, 32'h1);

        // Stalled read has no side effect and leaves dout alone
        rx_valid = 1'b1;
        rx_data = 8'hC3;
        idle();
        rx_valid = 1'b0;
        drive_cycle(1'b1, 1'b1, IO_RX, 32'h0, 4'h0, 1'b1);
        check("stall_dout", dout, 32'h5A);
        check("stall_rx_ready", {31'b0, rx_ready}, 32'h0);
        rd(IO_RX);
        check("stall_then_rd", dout, 32'hC3);

        // Counter clear beats a same-cycle retire
        instr_retired = 1'b1;
        wr(IO_CRST, 32'h0);
        instr_retired = 1'b0;
        rd(IO_INST);
        check("inst_clr", dout, 32'h0);
        rd(IO_CYC);
        check("cyc_after_clr", dout, CNT_EN ? 32'd1 : 32'd0);

        // 100 cycles, exactly 40 retire pulses in shuffled order
        for (int i = 0; i < 100; i++) pat[i] = (i < 40);
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = pat[i];
            pat[i] = pat[j];
            pat[j] = tmp;
        end
        wr(IO_CRST, 32'h0);
        for (int i = 0; i < 100; i++) begin
            instr_retired = pat[i];
            idle();
        end
        instr_retired = 1'b0;
        rd(IO_INST);
        check("inst_40", dout, CNT_EN ? 32'd40 : 32'd0);
        rd(IO_CYC);
        check("cyc_101", dout, CNT_EN ? 32'd101 : 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            tx_ready = ($urandom_range(0, 99) < ((i % 300) < 150 ? 15 : 70));
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data = 8'($urandom);
            op = $urandom_range(0, 3);
            drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                        offs[$urandom_range(0, 6)], $urandom,
                        (op >= 2) ? 4'($urandom_range(1, 15)) : 4'h0, op[0]);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        // Reset in the middle of traffic drops queued and held bytes
        idle();
        wr(IO_TX, 32'h11);
        wr(IO_TX, 32'h22);
        rx_valid = 1'b1;
        rx_data = 8'h77;
        tx_ready = 1'b1;
        do_reset();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("mid_rst_dout", dout, 32'h0);
        rd(IO_RX);
        check("mid_rst_rx_hold", dout, 32'h0);
        rd(IO_CTRL);
        check("mid_rst_ctrl", dout, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_io_responder.md
# mmio_io_responder

Memory-mapped I/O responder on the processor's data-side bus: decodes loads and stores with `addr[31]` set and answers them. It buffers transmit bytes toward the UART serializer in a small FIFO and holds one received byte from the UART deserializer. It also keeps the cycle counter and the retired-instruction counter. Read data returns one cycle after the access, matching the synchronous data-memory timing the processor already muxes against.

## Interface
Parameters:
- `TX_DEPTH`, default 8: transmit FIFO depth; power of two, minimum 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  processor stall; while high, accesses are ignored
- `addr`  in  32  byte address of the access
- `din`  in  32  store data
- `we`  in  4  byte write enables; any bit set means a write
- `re`  in  1  read strobe
- `dout`  out  32  registered read data
- `instr_retired`  in  1  one pulse per retired instruction
- `tx_data`  out  8  head byte of the transmit FIFO
- `tx_valid`  out  1  transmit FIFO not empty
- `tx_ready`  in  1  serializer accepts `tx_data` this cycle
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  received byte present
- `rx_ready`  out  1  holding register empty

## Operation
- Access condition: `sel = addr[31] & ~stall`. Register offset is `addr[7:0]`; higher address bits are ignored.
- 0x00 control/status, read:
  - bit0 = transmit FIFO not full
  - bit1 = receive byte held
  - bit2 = sticky transmit overflow
  - other bits 0
- 0x00 control/status, write: any write clears overflow.
- 0x04 receive data:
  - Read returns `{24'b0, rx_hold}`.
  - A read with a byte held clears `rx_full`.
  - A read with no byte held returns the stale byte and has no side effect.
- 0x08 transmit data:
  - A write with `we[0]` pushes `din[7:0]`.
  - A push while full is dropped and sets overflow.
- 0x10 cycle counter (read). 0x14 instruction counter (read).
- 0x18 counter reset: any write zeroes both counters.
- Unmapped offsets read 0; writes to them are ignored. Reads of write-only offsets return 0.
- Receive path:
  - `rx_ready = ~rx_full`, driven from the register, not combinational on the bus.
  - On `rx_valid & rx_ready`, capture `rx_data` and set `rx_full`.
- Transmit FIFO:
  - `tx_valid = ~empty`; `tx_data` is the head entry.
  - Pop on `tx_valid & tx_ready`.
  - Full/empty are judged on pre-cycle state. A push while full is rejected even if a pop occurs in the same cycle.
  - A push while empty appears on `tx_valid` the next cycle.
  - Pointers wrap modulo `TX_DEPTH`. The count is held in a `log2(TX_DEPTH)+1`-bit counter.
- Counters:
  - 32 bits, wrap 0xFFFFFFFF to 0.
  - The cycle counter increments every non-reset cycle.
  - The instruction counter increments on `instr_retired`.
  - A reset write in the same cycle as an increment leaves the counter at 0.
- Simultaneous `re` and `we`: the write takes effect and `dout` returns the pre-write value.

## Timing
- Read latency is 1 cycle: `dout` is valid the cycle after `re & sel`.
- When there is no selected read, `dout` holds its previous value.
- Side effects (receive pop, push, clears) take effect at the edge ending the access cycle. Status reads in the following cycle reflect them.
- Receive capture to `rx_ready` low: 1 cycle. A receive-data read to `rx_ready` high: 1 cycle.
- Reset values:
  - `dout` = 0, `tx_valid` = 0, `rx_ready` = 1
  - FIFO empty, overflow = 0, counters = 0, `rx_hold` = 0
- Reset mid-operation discards FIFO contents and any held byte, regardless of handshake state.
- While `stall` is high, `sel` is 0, so there are no side effects and `dout` holds. The receive and transmit handshakes and the counters keep running.

## Configuration
- `MMIO_COUNTERS_EN` defined: the cycle and instruction counters and the 0x18 reset are present.
- Undefined:
  - Counters are removed.
  - 0x10 and 0x14 read 0; 0x18 writes are ignored.
  - `instr_retired` is unused.

## Structure
- Shared package `io_map_pkg` holds:
  - offset constants `IO_CTRL`, `IO_RX`, `IO_TX`, `IO_CYC`, `IO_INST`, `IO_CRST`
  - control bit indices
  - the base-select bit index (31)
- One sub-module, `io_tx_fifo`, is natural: parameterised on `TX_DEPTH`, with push/pop/full/empty/head ports.
- The receive holding register, decode and counters live in the top module.

## Test plan
- Reset, then read 0x00 → `dout` = 0x1 next cycle, `tx_valid` = 0, `rx_ready` = 1.
- Write 0x41, 0x42, 0x43 to 0x08 with `tx_ready` = 0, then raise `tx_ready` → `tx_data` shows 0x41, 0x42, 0x43 on consecutive cycles, then `tx_valid` = 0.
- With `TX_DEPTH` = 8 and `tx_ready` = 0, write 9 bytes → the 9th is dropped and 0x00 reads 0x4. A write to 0x00 then makes it read 0x0.
- Present `rx_data` 0x5A with `rx_valid` → `rx_ready` falls next cycle and 0x00 reads 0x3. Reading 0x04 returns 0x0000005A and `rx_ready` rises the following cycle.
- Run 100 cycles with 40 `instr_retired` pulses, then read 0x14 → 40. Write 0x18, then read 0x10 → small value counted from 0. Without `MMIO_COUNTERS_EN`, both reads return 0.
- Hold `stall` high during a 0x04 read with a byte held → the byte is retained and `rx_ready` stays 0.
